// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the dino game: stages, lives, pause, timed interludes, LCD screen select.
// Optional GAME_FLOW_SCORE_EN adds a saturating obstacle score counter; otherwise score is tied to 0.
module game_flow_ctrl #(
   parameter int NUM_STAGES  = 4,
   parameter int LIVES       = 3,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int SCORE_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_start,
   input  logic               key_pause,
   input  logic               collision_detected,
   input  logic               stage_cleared,
   input  logic               obstacle_passed,
   output logic               run_game,
   output logic               stage_load,
   output logic [3:0]         stage_idx,
   output logic [3:0]         lives,
   output logic [2:0]         screen_sel,
   output logic               led_red,
   output logic               led_green,
   output logic [SCORE_W-1:0] score
);

   localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [3:0] LAST_STAGE = 4'(NUM_STAGES - 1);
   localparam logic [3:0] LIVES_INIT = 4'(LIVES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PAUSE   = 3'd2,
      S_HIT     = 3'd3,
      S_STG_CLR = 3'd4,
      S_OVER    = 3'd5,
      S_ALL_CLR = 3'd6
   } state_t;

   state_t state, next_state;

   logic               start_q, pause_q;
   logic               start_edge, pause_edge;
   logic [TIMER_W-1:0] timer, timer_nxt;
   logic [3:0]         idx_nxt, lives_nxt;
   logic               load_nxt, run_nxt, red_nxt, green_nxt;
   logic [2:0]         sel_nxt;

   // key_q resets high so a key held through reset cannot produce an edge
   assign start_edge = key_start & ~start_q;
   assign pause_edge = key_pause & ~pause_q;

   always_comb begin
      next_state = state;
      idx_nxt    = stage_idx;
      lives_nxt  = lives;
      timer_nxt  = timer;
      load_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_edge) begin
               next_state = S_RUN;
               idx_nxt    = 4'd0;
               lives_nxt  = LIVES_INIT;
               load_nxt   = 1'b1;
            end
         end
         S_RUN: begin
            if (collision_detected) begin
               if (lives <= 4'd1) begin
                  next_state = S_OVER;
                  lives_nxt  = 4'd0;
               end else begin
                  next_state = S_HIT;
                  lives_nxt  = lives - 4'd1;
                  timer_nxt  = TIMER_LOAD;
               end
            end else if (stage_cleared) begin
               if (stage_idx >= LAST_STAGE) begin
                  next_state = S_ALL_CLR;
               end else begin
                  next_state = S_STG_CLR;
                  timer_nxt  = TIMER_LOAD;
               end
            end else if (pause_edge) begin
               next_state = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (pause_edge) next_state = S_RUN;
         end
         S_HIT: begin
            if (timer == '0 || start_edge) begin
               next_state = S_RUN;
               load_nxt   = 1'b1;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         S_STG_CLR: begin
            if (timer == '0 || start_edge) begin
               next_state = S_RUN;
               load_nxt   = 1'b1;
               if (stage_idx < LAST_STAGE) idx_nxt = stage_idx + 4'd1;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         S_OVER, S_ALL_CLR: begin
            if (start_edge) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Outputs are decoded from next_state so they switch on the same edge as the state
   always_comb begin
      run_nxt   = 1'b0;
      red_nxt   = 1'b0;
      green_nxt = 1'b1;
      sel_nxt   = 3'd0;
      case (next_state)
         S_IDLE:    sel_nxt = 3'd0;
         S_RUN: begin
            sel_nxt = 3'd1;
            run_nxt = 1'b1;
         end
         S_PAUSE:   sel_nxt = 3'd2;
         S_HIT: begin
            sel_nxt   = 3'd3;
            red_nxt   = 1'b1;
            green_nxt = 1'b0;
         end
         S_STG_CLR: sel_nxt = 3'd4;
         S_OVER: begin
            sel_nxt   = 3'd5;
            red_nxt   = 1'b1;
            green_nxt = 1'b0;
         end
         S_ALL_CLR: begin
            sel_nxt = 3'd6;
            red_nxt = 1'b1;
         end
         default:   sel_nxt = 3'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         start_q    <= 1'b1;
         pause_q    <= 1'b1;
         timer      <= '0;
         stage_idx  <= 4'd0;
         lives      <= LIVES_INIT;
         stage_load <= 1'b0;
         run_game   <= 1'b0;
         screen_sel <= 3'd0;
         led_red    <= 1'b0;
         led_green  <= 1'b1;
      end else begin
         state      <= next_state;
         start_q    <= key_start;
         pause_q    <= key_pause;
         timer      <= timer_nxt;
         stage_idx  <= idx_nxt;
         lives      <= lives_nxt;
         stage_load <= load_nxt;
         run_game   <= run_nxt;
         screen_sel <= sel_nxt;
         led_red    <= red_nxt;
         led_green  <= green_nxt;
      end
   end

`ifdef GAME_FLOW_SCORE_EN
   logic [SCORE_W-1:0] score_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         score_r <= '0;
      end else if (state == S_IDLE && next_state == S_RUN) begin
         score_r <= '0;
      end else if (state == S_RUN && obstacle_passed && score_r != {SCORE_W{1'b1}}) begin
         score_r <= score_r + 1'b1;
      end
   end

   assign score = score_r;
`else
   logic unused_obstacle;

   assign unused_obstacle = obstacle_passed;
   assign score = '0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with NUM_STAGES=2, LIVES=3, HOLD_CYCLES=8, SCORE_W=2.
// Expected values are hand-computed; score expectations depend on GAME_FLOW_SCORE_EN.
module tb_game_flow_ctrl;

   localparam int SCORE_W = 2;
`ifdef GAME_FLOW_SCORE_EN
   localparam int SAT_SCORE = 3;
`else
   localparam int SAT_SCORE = 0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               key_start = 1'b0;
   logic               key_pause = 1'b0;
   logic               collision_detected = 1'b0;
   logic               stage_cleared = 1'b0;
   logic               obstacle_passed = 1'b0;
   logic               run_game, stage_load, led_red, led_green;
   logic [3:0]         stage_idx, lives;
   logic [2:0]         screen_sel;
   logic [SCORE_W-1:0] score;

   int tests_run = 0;
   int tests_failed = 0;

   game_flow_ctrl #(
      .NUM_STAGES(2), .LIVES(3), .HOLD_CYCLES(8), .SCORE_W(SCORE_W)
   ) dut (
      .clk(clk), .rst(rst), .key_start(key_start), .key_pause(key_pause),
      .collision_detected(collision_detected), .stage_cleared(stage_cleared),
      .obstacle_passed(obstacle_passed), .run_game(run_game), .stage_load(stage_load),
      .stage_idx(stage_idx), .lives(lives), .screen_sel(screen_sel),
      .led_red(led_red), .led_green(led_green), .score(score)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_screen(input string tag, input int sel, input int run, input int red,
                               input int green);
      check({tag, ".sel"}, 32'(screen_sel), 32'(sel));
      check({tag, ".run"}, 32'(run_game), 32'(run));
      check({tag, ".red"}, 32'(led_red), 32'(red));
      check({tag, ".green"}, 32'(led_green), 32'(green));
   endtask

   task automatic press_start();
      key_start = 1'b1;
      tick();
   endtask

   task automatic release_start();
      key_start = 1'b0;
      tick();
   endtask

   task automatic press_pause();
      key_pause = 1'b1;
      tick();
      key_pause = 1'b0;
   endtask

   initial begin
      // 1: reset with start held; held key must not start a game
      key_start = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_screen("rst_idle", 0, 0, 0, 1);
      check("rst_lives", 32'(lives), 3);
      check("rst_idx", 32'(stage_idx), 0);
      check("rst_load", 32'(stage_load), 0);
      check("rst_score", 32'(score), 0);
      tick();
      check("held_key_idle", 32'(screen_sel), 0);
      check("held_key_load", 32'(stage_load), 0);

      // 2: start, pause, resume
      release_start();
      press_start();
      check_screen("start", 1, 1, 0, 1);
      check("start_idx", 32'(stage_idx), 0);
      check("start_lives", 32'(lives), 3);
      check("start_load", 32'(stage_load), 1);
      release_start();
      check("load_one_cycle", 32'(stage_load), 0);
      press_pause();
      check_screen("pause", 2, 0, 0, 1);
      tick();
      press_pause();
      check_screen("resume", 1, 1, 0, 1);
      check("resume_no_load", 32'(stage_load), 0);
      tick();

      // 6: score saturation in RUN, frozen in PAUSE
      obstacle_passed = 1'b1;
      repeat (5) tick();
      obstacle_passed = 1'b0;
      check("score_sat", 32'(score), SAT_SCORE);
      press_pause();
      obstacle_passed = 1'b1;
      repeat (2) tick();
      obstacle_passed = 1'b0;
      check("score_paused", 32'(score), SAT_SCORE);
      press_pause();
      tick();

      // 3: collision -> HIT, timer expiry restarts the same stage
      collision_detected = 1'b1;
      tick();
      collision_detected = 1'b0;
      check_screen("hit1", 3, 0, 1, 0);
      check("hit1_lives", 32'(lives), 2);
      repeat (7) tick();
      check("hit1_still", 32'(screen_sel), 3);
      tick();
      check_screen("hit1_exit", 1, 1, 0, 1);
      check("hit1_idx", 32'(stage_idx), 0);
      check("hit1_load", 32'(stage_load), 1);
      tick();
      check("hit1_load_off", 32'(stage_load), 0);
      collision_detected = 1'b1;
      tick();
      collision_detected = 1'b0;
      check("hit2_sel", 32'(screen_sel), 3);
      check("hit2_lives", 32'(lives), 1);
      press_start();
      check("hit2_skip", 32'(screen_sel), 1);
      check("hit2_skip_load", 32'(stage_load), 1);
      release_start();
      collision_detected = 1'b1;
      tick();
      collision_detected = 1'b0;
      check_screen("over", 5, 0, 1, 0);
      check("over_lives", 32'(lives), 0);
      check("over_score", 32'(score), SAT_SCORE);
      press_start();
      check_screen("over_idle", 0, 0, 0, 1);
      release_start();

      // 4: stage clear progression and all-clear
      press_start();
      check("new_game_score", 32'(score), 0);
      check("new_game_lives", 32'(lives), 3);
      release_start();
      stage_cleared = 1'b1;
      tick();
      stage_cleared = 1'b0;
      check_screen("stg_clr", 4, 0, 0, 1);
      press_start();
      check("stg_idx", 32'(stage_idx), 1);
      check("stg_load", 32'(stage_load), 1);
      check("stg_run", 32'(screen_sel), 1);
      release_start();
      stage_cleared = 1'b1;
      tick();
      check_screen("all_clr", 6, 0, 1, 1);
      tick();
      stage_cleared = 1'b0;
      check("all_clr_hold", 32'(screen_sel), 6);
      press_start();
      check("all_clr_idle", 32'(screen_sel), 0);
      release_start();

      // 5: collision beats stage clear; both ignored in PAUSE
      press_start();
      release_start();
      collision_detected = 1'b1;
      stage_cleared = 1'b1;
      tick();
      collision_detected = 1'b0;
      stage_cleared = 1'b0;
      check("prio_sel", 32'(screen_sel), 3);
      check("prio_idx", 32'(stage_idx), 0);
      check("prio_lives", 32'(lives), 2);
      press_start();
      release_start();
      press_pause();
      collision_detected = 1'b1;
      stage_cleared = 1'b1;
      key_start = 1'b1;
      tick();
      tick();
      collision_detected = 1'b0;
      stage_cleared = 1'b0;
      key_start = 1'b0;
      check("pause_ign_sel", 32'(screen_sel), 2);
      check("pause_ign_lives", 32'(lives), 2);
      check("pause_ign_idx", 32'(stage_idx), 0);

      // reset in the middle of a HIT interlude
      press_pause();
      collision_detected = 1'b1;
      tick();
      collision_detected = 1'b0;
      check("pre_rst_hit", 32'(screen_sel), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_screen("mid_rst", 0, 0, 0, 1);
      check("mid_rst_lives", 32'(lives), 3);
      check("mid_rst_load", 32'(stage_load), 0);
      tick();
      check("mid_rst_stays", 32'(screen_sel), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised top-level game-flow controller for the dino game, the successor to the single-level start/run/over/clear controller. Adds multi-stage progression, a lives counter, pause/resume, timed hit and stage-clear interludes, and an encoded screen selector. Sits between the keypad and the game core/obstacle engine. Drives run enable, stage restart and status LEDs, and provides the select for the text-LCD screen mux.

Parameters:
NUM_STAGES, 4, number of stages; legal range 1..16.
LIVES, 3, lives granted at game start; legal range 1..15.
HOLD_CYCLES, 50_000_000, clk cycles spent in the HIT and STAGE_CLR interludes; must be at least 1.
SCORE_W, 16, score counter width; used only with SCORE_EN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key_start  in  1  keypad '*' level, debounced upstream
key_pause  in  1  keypad '#' level, debounced upstream
collision_detected  in  1  level from the game core
stage_cleared  in  1  level from the game core
obstacle_passed  in  1  one-cycle pulse per avoided obstacle
run_game  out  1  game core advances while this is 1
stage_load  out  1  one-cycle pulse: game core reloads the stage at stage_idx
stage_idx  out  4  current stage, 0-based
lives  out  4  remaining lives
screen_sel  out  3  0 START, 1 PLAY, 2 PAUSE, 3 HIT, 4 STG_CLR, 5 OVER, 6 ALL_CLR
led_red  out  1  status LED
led_green  out  1  status LED
score  out  SCORE_W  obstacles passed in the current game

Behaviour:
- All logic is clocked on the rising edge of clk. rst is synchronous and active-high.
- Key edges: each key has a registered delayed copy; edge = key & ~key_q. key_q resets to 1, so a key held through reset does not trigger.
- States: IDLE, RUN, PAUSE, HIT, STG_CLR, OVER, ALL_CLR.
- Outputs are registered and decoded from next_state, so they change on the same edge as the state register.
- Reset values: state IDLE, run_game 0, stage_load 0, stage_idx 0, lives LIVES, screen_sel 0, led_red 0, led_green 1, score 0, timer 0.
- IDLE (sel 0, green 1): start edge -> RUN. On that edge: stage_idx=0, lives=LIVES, score=0, stage_load=1.
- RUN (sel 1, run_game 1, green 1): events are evaluated in this priority order.
  1. collision_detected: if lives==1 -> OVER with lives=0; otherwise -> HIT with lives decremented.
  2. stage_cleared: if stage_idx==NUM_STAGES-1 -> ALL_CLR; otherwise -> STG_CLR.
  3. pause edge -> PAUSE.
- PAUSE (sel 2, run_game 0, green 1): pause edge -> RUN with no stage_load. collision_detected, stage_cleared and start edges are ignored.
- HIT (sel 3, red 1, green 0): timer loads HOLD_CYCLES-1 on entry. Exits when timer==0 or on a start edge (skip) -> RUN with stage_load=1; stage_idx is unchanged (same stage restarts).
- STG_CLR (sel 4, green 1): timer loads on entry as in HIT. Exits on timer==0 or a start edge -> RUN with stage_idx+1 and stage_load=1.
- OVER (sel 5, red 1, green 0): start edge -> IDLE.
- ALL_CLR (sel 6, red 1, green 1): start edge -> IDLE.
- stage_load is high for exactly one cycle per entry into RUN from IDLE, HIT or STG_CLR. It is never asserted on resume from PAUSE.
- The timer decrements by 1 each cycle while in HIT or STG_CLR and holds its value in all other states.
- stage_idx never exceeds NUM_STAGES-1. lives never underflows.
- Inputs are sampled only in the states listed above; a level left high does not retrigger until RUN is re-entered.
- Reset in any state, including mid-interlude, returns all registers to their reset values on the next edge.
- Unused state encodings recover to IDLE.

Optional Feature:
GAME_FLOW_SCORE_EN.
- Defined: score increments by 1 on each cycle where obstacle_passed=1 and the state is RUN. score saturates at 2^SCORE_W-1 and clears to 0 on the IDLE->RUN transition. It holds its value in all other states, so it remains readable in OVER and ALL_CLR.
- Undefined: score is tied to 0, obstacle_passed is ignored, and no counter is synthesised.

Test Plan:
1. rst high for 2 cycles with key_start held, then rst low, key still held -> remains IDLE; sel=0, green=1, stage_load never asserted.
2. Start edge -> next edge: run_game=1, sel=1, stage_idx=0, lives=3, stage_load=1 for exactly 1 cycle. Pause edge -> run_game=0, sel=2. Pause edge again -> sel=1, no stage_load.
3. HOLD_CYCLES=8; collision in RUN -> lives=2, sel=3, red=1. After 8 cycles: sel=1, stage_idx=0, stage_load pulse. Repeat the collision twice -> second HIT, then sel=5 with lives=0. Start edge -> sel=0.
4. NUM_STAGES=2; stage_cleared -> sel=4; start edge skips the timer -> stage_idx=1, stage_load=1. stage_cleared again -> sel=6. Start edge -> IDLE.
5. collision_detected and stage_cleared asserted in the same cycle in RUN -> HIT taken, stage_idx unchanged, lives decremented. Both asserted in PAUSE -> no state change.
6. With GAME_FLOW_SCORE_EN, SCORE_W=2: 5 obstacle_passed pulses in RUN -> score=3 (saturated). 2 pulses while in PAUSE -> score unchanged. New game -> score=0. Without the macro, score=0 throughout.
